// File: rtl/svp_pkg.sv
// Shared types for the svp capture path: controller state encoding visible on the
// state debug port and used by the bench to follow the capture sequence.
package svp_pkg;

  typedef enum logic [1:0] {
    SVP_CAP_IDLE  = 2'd0,
    SVP_CAP_PRE   = 2'd1,
    SVP_CAP_POST  = 2'd2,
    SVP_CAP_DRAIN = 2'd3
  } svp_cap_state_t;

endpackage

// File: rtl/svp_capture_buffer_if.sv
// Sample input and drain stream of the capture buffer. The buffer is the slave side.
interface svp_capture_buffer_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int AW    = 8
);

  // Handshake: in_valid has no back-pressure (a sample is either taken or dropped by
  // the decimator). On the drain side a beat transfers on a clock edge where
  // out_valid && out_ready; while out_valid=1 and out_ready=0 the beat holds stable.
  logic                   in_valid;
  logic [NCH*WIDTH-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*WIDTH-1:0]   out_data;
  logic [AW+1:0]          out_idx;
  logic                   out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/svp_cap_ram.sv
// Simple dual-port sample memory: one write port, one registered read port with
// read enable; the read register holds its value while re=0. No reset on the array.
module svp_cap_ram #(
  parameter int DEPTH = 256,
  parameter int DW    = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/svp_capture_buffer.sv
// Triggered multi-channel capture buffer: decimated pre/post-trigger window stored in a
// circular memory, then drained oldest-first with a trigger-relative index per beat.
module svp_capture_buffer
  import svp_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 256,
  parameter int DEC_W = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig,
  input  logic [DEC_W-1:0]         dec_ratio,
  input  logic [$clog2(DEPTH):0]   pre_len,
  input  logic [$clog2(DEPTH):0]   post_len,
  svp_capture_buffer_if.slave      bus,
  output logic                     busy,
  output logic                     done,
  output svp_cap_state_t           state
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = NCH * WIDTH;
  localparam int IW = AW + 2;
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_C   = (AW+1)'(1);
  localparam logic [DEC_W-1:0] DEC_ONE = DEC_W'(1);

  svp_cap_state_t state_q, state_d;

  logic [AW-1:0]    wptr, wptr_next, rd_start, rd_addr;
  logic [AW:0]      fill, fill_next, pre_q, post_q, post_cnt, npre, rd_cnt, total;
  logic [AW:0]      pre_clamp, post_room, post_clamp;
  logic [DEC_W-1:0] dec_cnt, dec_last;
  logic             capturing, store, post_full, drain_end;

  logic             s1_valid, s1_last;
  logic [IW-1:0]    s1_idx;
  logic             out_fire, out_load, s1_free, rd_en;
  logic [DW-1:0]    rd_data;

  // Window lengths are clamped so pre + post never exceeds the memory.
  always_comb begin
    pre_clamp  = (pre_len > DEPTH_C) ? DEPTH_C : pre_len;
    post_room  = DEPTH_C - pre_clamp;
    post_clamp = (post_len > post_room) ? post_room : post_len;
  end

  assign dec_last  = (dec_ratio > DEC_ONE) ? dec_ratio - DEC_ONE : '0;
  assign post_full = (post_cnt == post_q);
  assign capturing = (state_q == SVP_CAP_PRE) || ((state_q == SVP_CAP_POST) && !post_full);
  assign store     = capturing && bus.in_valid && (dec_cnt == '0);
  assign wptr_next = wptr + AW'(store);
  assign fill_next = (store && (fill != pre_q)) ? fill + ONE_C : fill;
  assign total     = npre + post_q;

  // Drain pipeline: RAM read register (stage 1) feeding the output register.
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign out_load  = s1_valid && (!bus.out_valid || bus.out_ready);
  assign s1_free   = !s1_valid || out_load;
  assign rd_en     = (state_q == SVP_CAP_DRAIN) && (rd_cnt != total) && s1_free;
  assign rd_addr   = rd_start + rd_cnt[AW-1:0];
  assign drain_end = (state_q == SVP_CAP_DRAIN) &&
                     ((total == '0) || (out_fire && bus.out_last));

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = SVP_CAP_IDLE;
    end else begin
      case (state_q)
        SVP_CAP_IDLE:  if (arm)       state_d = SVP_CAP_PRE;
        SVP_CAP_PRE:   if (trig)      state_d = SVP_CAP_POST;
        SVP_CAP_POST:  if (post_full) state_d = SVP_CAP_DRAIN;
        SVP_CAP_DRAIN: if (drain_end) state_d = SVP_CAP_IDLE;
        default:                      state_d = SVP_CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= SVP_CAP_IDLE;
      done          <= 1'b0;
      wptr          <= '0;
      fill          <= '0;
      pre_q         <= '0;
      post_q        <= '0;
      post_cnt      <= '0;
      npre          <= '0;
      rd_start      <= '0;
      rd_cnt        <= '0;
      dec_cnt       <= '0;
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_idx        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (abort) begin
        s1_valid      <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        case (state_q)
          SVP_CAP_IDLE: begin
            if (arm) begin
              pre_q    <= pre_clamp;
              post_q   <= post_clamp;
              wptr     <= '0;
              fill     <= '0;
              dec_cnt  <= '0;
              post_cnt <= '0;
              npre     <= '0;
              rd_start <= '0;
              rd_cnt   <= '0;
            end
          end
          SVP_CAP_PRE, SVP_CAP_POST: begin
            wptr <= wptr_next;
            if (capturing && bus.in_valid)
              dec_cnt <= (dec_cnt >= dec_last) ? '0 : dec_cnt + DEC_ONE;
            if (state_q == SVP_CAP_PRE) begin
              fill <= fill_next;
              // The store in the trigger cycle is already part of fill_next.
              if (trig) begin
                rd_start <= wptr_next - fill_next[AW-1:0];
                npre     <= fill_next;
              end
            end else if (store) begin
              post_cnt <= post_cnt + ONE_C;
            end
          end
          SVP_CAP_DRAIN: begin
            if (rd_en) begin
              rd_cnt  <= rd_cnt + ONE_C;
              s1_idx  <= IW'(rd_cnt) - IW'(npre);
              s1_last <= (rd_cnt == total - ONE_C);
            end
            if (rd_en)         s1_valid <= 1'b1;
            else if (out_load) s1_valid <= 1'b0;
            if (out_load) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= rd_data;
              bus.out_idx   <= s1_idx;
              bus.out_last  <= s1_last;
            end else if (out_fire) begin
              bus.out_valid <= 1'b0;
            end
            if (drain_end) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  svp_cap_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wptr),
    .wdata (bus.in_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign busy  = (state_q != SVP_CAP_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_svp_capture_buffer.sv
// Directed bench for svp_capture_buffer: capture windows on ramp data, drain and
// compare against hand-derived windows, plus abort / reset recovery.
module tb_svp_capture_buffer;
  import svp_pkg::*;

  localparam int NCH   = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int DEC_W = 8;
  localparam int AW    = 4;
  localparam int DW    = NCH * WIDTH;

  logic                clk = 1'b0;
  logic                rstb = 1'b0;
  logic                arm = 1'b0;
  logic                abort = 1'b0;
  logic                trig = 1'b0;
  logic [DEC_W-1:0]    dec_ratio = '0;
  logic [AW:0]         pre_len = '0;
  logic [AW:0]         post_len = '0;
  logic                busy, done;
  svp_cap_state_t      state;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0]  exp_q[$];
  logic [DW-1:0]  got_d[$];
  logic [AW+1:0]  got_i[$];
  logic           got_l[$];

  svp_capture_buffer_if #(.NCH(NCH), .WIDTH(WIDTH), .AW(AW)) bus ();

  svp_capture_buffer #(
    .NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH), .DEC_W(DEC_W)
  ) dut (
    .clk(clk), .rstb(rstb), .arm(arm), .abort(abort), .trig(trig),
    .dec_ratio(dec_ratio), .pre_len(pre_len), .post_len(post_len),
    .bus(bus), .busy(busy), .done(done), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int v);
    logic [15:0] b;
    b = 16'(v);
    return {b + 16'h3000, b + 16'h2000, b + 16'h1000, b};
  endfunction

  // driver: arm, then feed a ramp 0.. with trig on sample trig_at
  task automatic arm_feed(input int dec, input int prel, input int postl,
                          input int trig_at, input int abort_after);
    int v;
    bit stop;
    dec_ratio = DEC_W'(dec);
    pre_len   = (AW+1)'(prel);
    post_len  = (AW+1)'(postl);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("arm_state", state, SVP_CAP_PRE);
    v = 0;
    stop = 1'b0;
    while (!stop && v < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data  = mk(v);
      trig = (v == trig_at);
      tick();
      trig = 1'b0;
      if (abort_after >= 0 && v >= trig_at + abort_after) stop = 1'b1;
      if (state == SVP_CAP_DRAIN) stop = 1'b1;
      v++;
    end
    bus.in_valid = 1'b0;
    check("feed_bound", 64'(stop), 64'd1);
  endtask

  // driver + scoreboard: drain the window, then compare against first+i*step
  task automatic drain_check(input bit rnd, input int first, input int step,
                             input int np, input int n, input string tag);
    bit            seen_done, stalled;
    logic [DW-1:0] hd;
    logic [AW+1:0] hi;
    logic          hl;
    int            cnt;
    got_d.delete();
    got_i.delete();
    got_l.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(mk(first + i * step));
    seen_done = 1'b0;
    stalled   = 1'b0;
    hd = '0; hi = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_hold_data"}, 64'(bus.out_data), 64'(hd));
        check({tag, "_hold_idx"}, 64'(bus.out_idx), 64'(hi));
        check({tag, "_hold_last"}, 64'(bus.out_last), 64'(hl));
      end
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(bus.out_data);
        got_i.push_back(bus.out_idx);
        got_l.push_back(bus.out_last);
      end
      stalled = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      hi = bus.out_idx;
      hl = bus.out_last;
      tick();
      if (done) seen_done = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    check({tag, "_idle"}, state, SVP_CAP_IDLE);
    check({tag, "_valid_off"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_beats"}, 64'(got_d.size()), 64'(n));
    cnt = (got_d.size() < n) ? got_d.size() : n;
    for (int i = 0; i < cnt; i++) begin
      logic [AW+1:0] ei;
      ei = (AW+2)'(i - np);
      check({tag, "_data"}, 64'(got_d[i]), 64'(exp_q.pop_front()));
      check({tag, "_idx"}, 64'(got_i[i]), 64'(ei));
      check({tag, "_last"}, 64'(got_l[i]), 64'(i == n - 1));
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset state
    rstb = 1'b0;
    repeat (3) tick();
    check("rst_state", state, SVP_CAP_IDLE);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_idx", 64'(bus.out_idx), 64'd0);
    check("rst_last", 64'(bus.out_last), 64'd0);
    rstb = 1'b1;
    tick();

    // pre=4 post=4, trig on sample 10: data 7..14, idx -4..3
    arm_feed(1, 4, 4, 10, -1);
    drain_check(1'b0, 7, 1, 4, 8, "basic");

    // decimate by 3, trig on stored sample 12: 9,12 | 15,18,21
    arm_feed(3, 2, 3, 12, -1);
    drain_check(1'b0, 9, 3, 2, 5, "dec3");

    // dec_ratio=0 (every sample), trig after one stored sample: npre=1
    arm_feed(0, 4, 4, 0, -1);
    drain_check(1'b0, 0, 1, 1, 5, "early_trig");

    // pre=10 post=10 -> post clamped to 6, window wraps memory: 11..26
    arm_feed(1, 10, 10, 20, -1);
    drain_check(1'b0, 11, 1, 10, 16, "clamp");

    // random back-pressure, same window as basic
    arm_feed(1, 4, 4, 10, -1);
    drain_check(1'b1, 7, 1, 4, 8, "stall");

    // empty window: no beats, done still pulses
    arm_feed(1, 0, 0, 0, -1);
    drain_check(1'b0, 0, 1, 0, 0, "empty");

    // abort two samples into POST
    arm_feed(1, 4, 4, 10, 2);
    check("abort_in_post", state, SVP_CAP_POST);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", state, SVP_CAP_IDLE);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    tick();
    check("abort_done2", 64'(done), 64'd0);
    arm_feed(1, 4, 4, 10, -1);
    drain_check(1'b0, 7, 1, 4, 8, "rearm_abort");

    // reset while draining
    arm_feed(1, 4, 4, 10, -1);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("mid_drain_valid", 64'(bus.out_valid), 64'd1);
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    check("rst_drain_state", state, SVP_CAP_IDLE);
    check("rst_drain_valid", 64'(bus.out_valid), 64'd0);
    check("rst_drain_done", 64'(done), 64'd0);
    check("rst_drain_idx", 64'(bus.out_idx), 64'd0);
    tick();
    check("rst_drain_done2", 64'(done), 64'd0);
    arm_feed(3, 2, 3, 12, -1);
    drain_check(1'b0, 9, 3, 2, 5, "rearm_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
